mmm_share_arbiter: RTL and testbench
====================================

# mmm_share_arbiter

Round-robin arbiter and sequencer that shares one bit-serial Montgomery modular multiplier (MMM) core between `NREQ` requesters, e.g. the square and multiply paths of the exponentiation unit, or two independent exponentiation channels.
- Grants the core to one requester at a time and drives the core's operand mux select, clear, operand-load and result-load strobes.
- Runs the fixed WIDTH+1-step MMM iteration, then returns a one-cycle done pulse to the winner.

## Interface
Parameters:
- `WIDTH`, 8: operand width; the MMM iterates WIDTH+1 steps.
- `NREQ`, 2: number of requesters, ≥2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ena`  in  1  clock enable; when 0, all state, counters and the pointer hold.
- `req`  in  NREQ  level request per requester.
- `grant`  out  NREQ  one-hot owner of the MMM core; 0 when idle.
- `sel`  out  $clog2(NREQ)  operand/result mux select = index of `grant`; 0 when idle.
- `rst_mmm`  out  1  active-low MMM clear (0 = core held cleared).
- `ld_a`  out  1  load operands into the MMM.
- `ld_r`  out  1  capture the MMM result into the owner's result register.
- `done`  out  NREQ  one-cycle pulse to the owner when its result is captured.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- State machine states are IDLE, LOAD, RUN and CAPTURE.
- **IDLE**
  - `rst_mmm`=0; all other outputs are 0.
  - If any `req` bit is set, pick the winner round-robin from the pointer, register it as `grant`/`sel`, and go to LOAD.
- **LOAD**: `rst_mmm`=1, `ld_a`=1; clear the step counter; go to RUN.
- **RUN**
  - `rst_mmm`=1; the step counter increments each enabled cycle.
  - When the counter equals WIDTH, go to CAPTURE. RUN lasts exactly WIDTH+1 cycles.
- **CAPTURE**
  - `rst_mmm`=1, `ld_r`=1, and `done[owner]`=1.
  - Update the pointer to owner+1, wrapping from NREQ-1 to 0; go to IDLE.
- Round-robin rule: the search starts at the pointer index and takes the lowest index at or above it, wrapping. The pointer changes only in CAPTURE.
- `grant` and `sel` are registered. They are stable from LOAD through CAPTURE and clear on entry to IDLE.
- A `req` deassertion after grant is ignored: the operation completes and `done` still pulses.
- A `req` still high after its `done` counts as a new request, but other pending requesters win first.
- Step counter width is $clog2(WIDTH+1), compared against WIDTH with no overflow.
- Reset mid-operation:
  - State goes to IDLE; `grant`, `sel` and the pointer go to 0; the counter clears.
  - No `done` pulse is issued; the MMM is held cleared.
- Reset values: `grant`=0, `sel`=0, `rst_mmm`=0, `ld_a`=0, `ld_r`=0, `done`=0, `busy`=0.
- The state encoding is exactly 2 bits; unreachable codes are not possible.

## Timing
- Request to grant: `req` sampled high in IDLE at edge N; `grant` and `ld_a` are high from edge N.
- Grant to done: `done` rises WIDTH+2 cycles after `grant` rises and lasts 1 cycle.
- `grant` is high for WIDTH+3 cycles.
- Back-to-back spacing: one IDLE cycle with `rst_mmm`=0 is mandatory between operations, giving a period of WIDTH+4 cycles per grant.
- Strobe placement:
  - `ld_a` is high only in the first granted cycle.
  - `ld_r` is coincident with `done`.
- `ena`=0 stretches any state by the number of disabled cycles. Outputs decode from the current state and hold their values. A `done` pulse stalled by `ena` stays high until the next enabled edge.

## Structure
- Shared package `mmm_ctrl_pkg` holds:
  - the state enum `mmm_arb_state_t` (IDLE, LOAD, RUN, CAPTURE);
  - a function giving the step-counter width from WIDTH.
- One combinational sub-module is natural: `rr_pick #(NREQ)`. Inputs `req` and `ptr`; outputs `valid`, one-hot `win` and `win_idx`.
- The FSM, counter and pointer live in the top.

## Test plan
All scenarios use WIDTH=8, NREQ=2.
- **Single request**: `req`=01 from idle → `grant`=01 and `ld_a`=1 next cycle; `ld_r`=`done`=01 exactly 10 cycles later; `grant`=00 after 11 cycles; `rst_mmm`=0 for 1 cycle.
- **Contention alternation**: `req`=11 held continuously → grants 01, 10, 01, 10, each period 12 cycles; `done` alternates 01/10.
- **Requester drop**: `req`=10, dropped to 00 two cycles after grant → operation completes, `done`=10 at the normal cycle, then idle.
- **`ena` stall**: `ena`=0 for 5 cycles during RUN → `done` delayed by exactly 5 cycles; counter and outputs frozen during the stall.
- **Reset mid-RUN**: `rst` pulsed at step 4 → all outputs 0 immediately, no `done`; the next `req`=10 is granted normally with the pointer at 0.
- **Pointer wrap**: `req`=10 served, then `req`=11 → grant 01, proving the pointer wrapped from 1 to 0.

Source files
------------

// File: rtl/mmm_ctrl_pkg.sv
// rtl/mmm_ctrl_pkg.sv - shared types and helpers for the MMM share arbiter
//
// Purpose: state enum for the arbiter/sequencer FSM and the step-counter
//          width helper.
// Ports:   none (package).
package mmm_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_RUN     = 2'd2,
    S_CAPTURE = 2'd3
  } mmm_arb_state_t;

  // Bits needed to count 0..width inclusive.
  function automatic int cnt_width(input int width);
    return (width < 1) ? 1 : $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mmm_share_arbiter_rr_pick.sv
// rtl/mmm_share_arbiter_rr_pick.sv - combinational round-robin winner select
//
// Purpose: picks the lowest requesting index at or above ptr, wrapping.
// Ports:   req     - request vector
//          ptr     - index where the search starts
//          valid   - at least one request is pending
//          win     - one-hot winner
//          win_idx - binary index of the winner
module rr_pick #(
  parameter int NREQ = 2,
  parameter int SW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [SW-1:0]   ptr,
  output logic            valid,
  output logic [NREQ-1:0] win,
  output logic [SW-1:0]   win_idx
);

  int          j;
  logic [SW-1:0] idx;

  always_comb begin
    valid   = 1'b0;
    win     = '0;
    win_idx = '0;
    j       = 0;
    idx     = '0;
    // Walk NREQ slots starting at ptr; first hit wins.
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      idx = SW'(j);
      if (!valid && req[idx]) begin
        valid    = 1'b1;
        win[idx] = 1'b1;
        win_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/mmm_share_arbiter.sv
// rtl/mmm_share_arbiter.sv - round-robin sharing of one bit-serial MMM core
//
// Purpose: grants the MMM core to one requester, sequences LOAD, the
//          WIDTH+1-step RUN and CAPTURE, then pulses done to the owner.
// Ports:   clk     - rising-edge clock
//          rst     - asynchronous active-high reset
//          ena     - clock enable, all state holds when low
//          req     - level request per requester
//          grant   - one-hot current owner, 0 when idle
//          sel     - binary index of the owner, 0 when idle
//          rst_mmm - active-low MMM clear
//          ld_a    - operand-load strobe (first granted cycle)
//          ld_r    - result-capture strobe
//          done    - one-cycle pulse to the owner at capture
//          busy    - FSM not idle
module mmm_share_arbiter
  import mmm_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] sel,
  output logic                    rst_mmm,
  output logic                    ld_a,
  output logic                    ld_r,
  output logic [NREQ-1:0]         done,
  output logic                    busy
);

  localparam int SW = $clog2(NREQ);
  localparam int CW = cnt_width(WIDTH);

  mmm_arb_state_t  state;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   ptr;

  logic            pick_valid;
  logic [NREQ-1:0] pick_win;
  logic [SW-1:0]   pick_idx;

  rr_pick #(
    .NREQ (NREQ),
    .SW   (SW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .valid   (pick_valid),
    .win     (pick_win),
    .win_idx (pick_idx)
  );

  assign busy = (state != S_IDLE);

  // Outputs are registered alongside the state so they always reflect the
  // state being entered; ena low freezes everything including the strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ptr     <= '0;
      grant   <= '0;
      sel     <= '0;
      rst_mmm <= 1'b0;
      ld_a    <= 1'b0;
      ld_r    <= 1'b0;
      done    <= '0;
    end else if (ena) begin
      case (state)
        S_IDLE: begin
          rst_mmm <= 1'b0;
          ld_a    <= 1'b0;
          ld_r    <= 1'b0;
          done    <= '0;
          if (pick_valid) begin
            state   <= S_LOAD;
            grant   <= pick_win;
            sel     <= pick_idx;
            rst_mmm <= 1'b1;
            ld_a    <= 1'b1;
          end
        end
        S_LOAD: begin
          cnt   <= '0;
          ld_a  <= 1'b0;
          state <= S_RUN;
        end
        S_RUN: begin
          // Counter stops at WIDTH so it never wraps.
          if (cnt == CW'(WIDTH)) begin
            state <= S_CAPTURE;
            ld_r  <= 1'b1;
            done  <= grant;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_CAPTURE: begin
          state   <= S_IDLE;
          ptr     <= (sel == SW'(NREQ - 1)) ? '0 : sel + SW'(1);
          cnt     <= '0;
          grant   <= '0;
          sel     <= '0;
          rst_mmm <= 1'b0;
          ld_r    <= 1'b0;
          done    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmm_share_arbiter.sv
// tb/tb_mmm_share_arbiter.sv - self-checking bench for mmm_share_arbiter
module tb_mmm_share_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ena = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] grant;
  logic [0:0] sel;
  logic       rst_mmm;
  logic       ld_a;
  logic       ld_r;
  logic [1:0] done;
  logic       busy;

  always #5 clk = ~clk;

  mmm_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .req     (req),
    .grant   (grant),
    .sel     (sel),
    .rst_mmm (rst_mmm),
    .ld_a    (ld_a),
    .ld_r    (ld_r),
    .done    (done),
    .busy    (busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Transaction-level reference: an operation is a timeline of WIDTH+3
  // granted cycles (age 0..WIDTH+2) followed by one mandatory idle cycle.
  logic m_busy;
  int   m_owner;
  int   m_age;
  int   m_ptr;

  logic [1:0] prev_grant, prev_done;
  int         g_cyc, d_cyc;
  logic [1:0] g_val, d_val;
  logic [1:0] g_vals[$];
  int         g_cycs[$];
  logic [1:0] d_vals[$];

  typedef struct {
    logic       rst;
    logic       ena;
    logic [1:0] req;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[13];

  function automatic logic [8:0] dut_out();
    return {grant, sel, rst_mmm, ld_a, ld_r, done, busy};
  endfunction

  function automatic logic [8:0] model_out();
    logic [1:0] g;
    logic       s;
    logic       cap;
    g = 2'b00;
    s = 1'b0;
    if (m_busy) begin
      g = (m_owner == 1) ? 2'b10 : 2'b01;
      s = (m_owner == 1);
    end
    cap = m_busy && (m_age == WIDTH + 2);
    return {g, s, m_busy, m_busy && (m_age == 0), cap, cap ? g : 2'b00, m_busy};
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_age   = 0;
    m_ptr   = 0;
  endtask

  task automatic model_step();
    int i;
    if (rst) begin
      model_reset();
    end else if (ena) begin
      if (!m_busy) begin
        for (int k = 0; k < NREQ; k++) begin
          i = (m_ptr + k) % NREQ;
          if (!m_busy && req[i]) begin
            m_busy  = 1'b1;
            m_owner = i;
            m_age   = 0;
          end
        end
      end else if (m_age == WIDTH + 2) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % NREQ;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic check_val(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got={g,s,rm,la,lr,d,b}=%b want=%b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    if (grant != 2'b00 && prev_grant == 2'b00) begin
      g_cyc = cyc;
      g_val = grant;
      g_vals.push_back(grant);
      g_cycs.push_back(cyc);
    end
    if (done != 2'b00 && prev_done == 2'b00) begin
      d_cyc = cyc;
      d_val = done;
      d_vals.push_back(done);
    end
    prev_grant = grant;
    prev_done  = done;
  endtask

  task automatic tick_chk(input string name);
    tick();
    check_val(name, dut_out(), model_out());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 2'b00;
    ena = 1'b1;
    tick_chk("reset");
    rst = 1'b0;
    g_vals.delete();
    g_cycs.delete();
    d_vals.delete();
    g_cyc = -100;
    d_cyc = -100;
  endtask

  initial begin
    model_reset();
    prev_grant = 2'b00;
    prev_done  = 2'b00;
    g_cyc = -100;
    d_cyc = -100;
    g_val = 2'b00;
    d_val = 2'b00;

    // Single request from idle, absolute expected values.
    tbl[0]  = '{1'b1, 1'b1, 2'b00, 9'b00_0_0_0_0_00_0};
    tbl[1]  = '{1'b0, 1'b1, 2'b01, 9'b01_0_1_1_0_00_1};
    for (int i = 2; i <= 10; i++)
      tbl[i] = '{1'b0, 1'b1, 2'b00, 9'b01_0_1_0_0_00_1};
    tbl[11] = '{1'b0, 1'b1, 2'b00, 9'b01_0_1_0_1_01_1};
    tbl[12] = '{1'b0, 1'b1, 2'b00, 9'b00_0_0_0_0_00_0};

    #1;
    check_val("reset_state", dut_out(), 9'b0);

    for (int i = 0; i < 13; i++) begin
      rst = tbl[i].rst;
      ena = tbl[i].ena;
      req = tbl[i].req;
      tick();
      check_val($sformatf("table[%0d]", i), dut_out(), tbl[i].exp);
    end

    // Contention from a fresh reset: 01,10,01,10 every 12 cycles.
    do_reset();
    req = 2'b11;
    for (int i = 0; i < 48; i++) tick_chk("contend");
    req = 2'b00;
    check_int("contend_grants", g_vals.size(), 4);
    check_int("contend_dones", d_vals.size(), 4);
    for (int k = 0; k < 4 && k < g_vals.size(); k++)
      check_int($sformatf("contend_grant[%0d]", k), int'(g_vals[k]), (k % 2 == 0) ? 1 : 2);
    for (int k = 1; k < 4 && k < g_cycs.size(); k++)
      check_int($sformatf("contend_period[%0d]", k), g_cycs[k] - g_cycs[k-1], WIDTH + 4);
    for (int k = 0; k < 4 && k < d_vals.size(); k++)
      check_int($sformatf("contend_done[%0d]", k), int'(d_vals[k]), (k % 2 == 0) ? 1 : 2);
    for (int i = 0; i < 12; i++) tick_chk("contend_drain");

    // Requester drop two cycles after grant.
    do_reset();
    req = 2'b10;
    tick_chk("drop_grant");
    tick_chk("drop_hold");
    tick_chk("drop_hold");
    req = 2'b00;
    for (int i = 0; i < 12; i++) tick_chk("drop_run");
    check_int("drop_done_lat", d_cyc - g_cyc, WIDTH + 2);
    check_int("drop_done_val", int'(d_val), 2);
    check_int("drop_idle", int'(busy), 0);

    // ena stall of 5 cycles during RUN.
    do_reset();
    req = 2'b01;
    tick_chk("stall_grant");
    req = 2'b00;
    for (int i = 0; i < 3; i++) tick_chk("stall_run");
    ena = 1'b0;
    for (int i = 0; i < 5; i++) tick_chk("stall_frozen");
    ena = 1'b1;
    for (int i = 0; i < 12; i++) tick_chk("stall_resume");
    check_int("stall_done_lat", d_cyc - g_cyc, WIDTH + 2 + 5);
    check_int("stall_done_val", int'(d_val), 1);

    // Reset mid-RUN: outputs clear at once, no done, pointer back to 0.
    do_reset();
    req = 2'b01;
    tick_chk("mrst_grant");
    req = 2'b00;
    for (int i = 0; i < 5; i++) tick_chk("mrst_run");
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_val("mrst_async", dut_out(), 9'b0);
    tick_chk("mrst_hold");
    rst = 1'b0;
    d_vals.delete();
    req = 2'b10;
    tick_chk("mrst_regrant");
    check_int("mrst_grant10", int'(grant), 2);
    req = 2'b00;
    for (int i = 0; i < 11; i++) tick_chk("mrst_serve");
    check_int("mrst_one_done", d_vals.size(), 1);

    // Pointer wrap: owner 1 served above, both request, 0 must win.
    req = 2'b11;
    tick_chk("wrap_grant");
    check_int("wrap_grant01", int'(grant), 1);
    req = 2'b00;
    for (int i = 0; i < 12; i++) tick_chk("wrap_drain");

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      req = 2'($urandom_range(0, 3));
      ena = ($urandom_range(0, 7) != 0);
      rst = ($urandom_range(0, 99) == 0);
      tick_chk("random");
    end
    rst = 1'b0;
    ena = 1'b1;
    req = 2'b00;
    for (int i = 0; i < 14; i++) tick_chk("random_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
